// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry skid behind the main register.
// Upstream ready is decoded from registered state only, so a downstream stall never reaches upstream combinationally.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W    = 96,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'({64'b0, 32'h13})
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              load, unload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Handshake outputs come from state alone; main holds NOP whenever the stage is empty.
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign load        = in_valid_i & in_ready_o;
  assign unload      = out_valid_o & out_ready_i;

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      BUSY:    occupancy_o = 2'd1;
      FULL:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Any same-cycle load is dropped; a same-cycle unload has already been sampled downstream.
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (load) begin
            state_d = BUSY;
            main_d  = in_data_i;
          end
        end
        BUSY: begin
          if (load && unload) begin
            main_d = in_data_i;
          end else if (load) begin
            state_d = FULL;
            skid_d  = in_data_i;
          end else if (unload) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        FULL: begin
          if (unload) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks for pipe_stage_skid at the default 96-bit width.
module tb_pipe_stage_skid;
  localparam int unsigned DW  = 96;
  localparam logic [DW-1:0] NOP = {64'b0, 32'h13};

  logic          clk, rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [DW-1:0] in_data_i, out_data_o;
  logic [1:0]    occupancy_o;
  int            passed, total;

  pipe_stage_skid #(.DATA_W(DW), .NOP_VALUE(NOP)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .occupancy_o(occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs are driven and outputs sampled there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; in_valid_i = 0; out_ready_i = 0; in_data_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1; idle();
    cyc(); cyc();
    rst = 0;
    cyc();
    total++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready act=%0b exp=1", in_ready_o); else passed++;
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid act=%0b exp=0", out_valid_o); else passed++;
    total++; if (occupancy_o !== 2'd0) $display("FAIL reset_occ act=%0d exp=0", occupancy_o); else passed++;
    total++; if (out_data_o !== NOP) $display("FAIL reset_data act=%h exp=%h", out_data_o, NOP); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid_i = 1; in_data_i = DW'(32'hA + i);
      #1;
      total++; if (in_ready_o !== 1'b1) $display("FAIL stream_in_ready i=%0d act=%0b exp=1", i, in_ready_o); else passed++;
      cyc();
      total++; if (out_valid_o !== 1'b1) $display("FAIL stream_valid i=%0d act=%0b exp=1", i, out_valid_o); else passed++;
      total++;
      if (out_data_o !== DW'(32'hA + i)) $display("FAIL stream_data i=%0d act=%h exp=%h", i, out_data_o, DW'(32'hA + i));
      else passed++;
    end
    in_valid_i = 0;
    cyc();
    total++; if (occupancy_o !== 2'd0) $display("FAIL stream_drain_occ act=%0d exp=0", occupancy_o); else passed++;
    total++; if (out_data_o !== NOP) $display("FAIL stream_drain_data act=%h exp=%h", out_data_o, NOP); else passed++;
  endtask

  task automatic test_stall_fill();
    do_reset();
    out_ready_i = 0;
    in_valid_i = 1; in_data_i = DW'(1); cyc();
    in_data_i = DW'(2); cyc();
    in_data_i = DW'(3); #1;
    total++; if (in_ready_o !== 1'b0) $display("FAIL stall_in_ready act=%0b exp=0", in_ready_o); else passed++;
    total++; if (occupancy_o !== 2'd2) $display("FAIL stall_occ act=%0d exp=2", occupancy_o); else passed++;
    total++; if (out_data_o !== DW'(1)) $display("FAIL stall_head act=%h exp=1", out_data_o); else passed++;
    cyc();
    total++; if (occupancy_o !== 2'd2) $display("FAIL stall_hold_occ act=%0d exp=2", occupancy_o); else passed++;
    out_ready_i = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      total++; if (out_valid_o !== 1'b1) $display("FAIL release_valid i=%0d act=%0b exp=1", i, out_valid_o); else passed++;
      total++; if (out_data_o !== DW'(i)) $display("FAIL release_data i=%0d act=%h exp=%0d", i, out_data_o, i); else passed++;
      cyc();
      if (i == 2) in_valid_i = 0;
    end
    total++; if (occupancy_o !== 2'd0) $display("FAIL release_empty act=%0d exp=0", occupancy_o); else passed++;
  endtask

  task automatic test_flush_full();
    do_reset();
    out_ready_i = 0;
    in_valid_i = 1; in_data_i = DW'(32'h11); cyc();
    in_data_i = DW'(32'h22); cyc();
    flush_i = 1; in_data_i = DW'(32'h33); cyc();
    flush_i = 0; in_valid_i = 0; #1;
    total++; if (occupancy_o !== 2'd0) $display("FAIL flush_full_occ act=%0d exp=0", occupancy_o); else passed++;
    total++; if (out_data_o !== NOP) $display("FAIL flush_full_data act=%h exp=%h", out_data_o, NOP); else passed++;
    out_ready_i = 1;
    cyc(); cyc();
    total++; if (out_valid_o !== 1'b0) $display("FAIL flush_full_leak act=%0b exp=0", out_valid_o); else passed++;
    // Load handshaking in the flush cycle from BUSY is discarded as well.
    in_valid_i = 1; in_data_i = DW'(32'h40); out_ready_i = 0; cyc();
    flush_i = 1; in_data_i = DW'(32'h44); cyc();
    flush_i = 0; in_valid_i = 0; #1;
    total++; if (out_valid_o !== 1'b0) $display("FAIL flush_load_valid act=%0b exp=0", out_valid_o); else passed++;
    total++; if (out_data_o !== NOP) $display("FAIL flush_load_data act=%h exp=%h", out_data_o, NOP); else passed++;
  endtask

  task automatic test_flush_stall();
    do_reset();
    out_ready_i = 0;
    in_valid_i = 1; in_data_i = DW'(32'h50); cyc();
    in_valid_i = 0; flush_i = 1; cyc();
    flush_i = 0; #1;
    total++; if (occupancy_o !== 2'd0) $display("FAIL flush_stall_occ act=%0d exp=0", occupancy_o); else passed++;
    total++; if (in_ready_o !== 1'b1) $display("FAIL flush_stall_ready act=%0b exp=1", in_ready_o); else passed++;
    in_valid_i = 1; in_data_i = DW'(32'h55); cyc();
    in_valid_i = 0; #1;
    total++; if (out_data_o !== DW'(32'h55)) $display("FAIL flush_resume_data act=%h exp=55", out_data_o); else passed++;
    total++; if (occupancy_o !== 2'd1) $display("FAIL flush_resume_occ act=%0d exp=1", occupancy_o); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready_i = 0;
    in_valid_i = 1; in_data_i = DW'(32'h61); cyc();
    in_data_i = DW'(32'h62); cyc();
    in_valid_i = 0;
    #2 rst = 1;
    #1;
    total++; if (out_valid_o !== 1'b0) $display("FAIL async_rst_valid act=%0b exp=0", out_valid_o); else passed++;
    total++; if (out_data_o !== NOP) $display("FAIL async_rst_data act=%h exp=%h", out_data_o, NOP); else passed++;
    total++; if (in_ready_o !== 1'b1) $display("FAIL async_rst_ready act=%0b exp=1", in_ready_o); else passed++;
    total++; if (occupancy_o !== 2'd0) $display("FAIL async_rst_occ act=%0d exp=0", occupancy_o); else passed++;
    rst = 0;
    cyc();
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic          ld, ul;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid_i  = ($urandom_range(0, 99) < 60);
      out_ready_i = ($urandom_range(0, 99) < 55);
      in_data_i   = {$urandom(), $urandom(), $urandom()};
      #1;
      total++;
      if (occupancy_o !== 2'(q.size())) $display("FAIL rand_occ c=%0d act=%0d exp=%0d", c, occupancy_o, q.size());
      else passed++;
      ld = in_valid_i & in_ready_o;
      ul = out_valid_o & out_ready_i;
      if (ul) begin
        total++;
        if (q.size() == 0) $display("FAIL rand_dup c=%0d act=%h exp=none", c, out_data_o);
        else if (out_data_o !== q[0]) $display("FAIL rand_data c=%0d act=%h exp=%h", c, out_data_o, q[0]);
        else passed++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (ld) q.push_back(in_data_i);
      cyc();
    end
    in_valid_i = 0; out_ready_i = 1;
    for (int k = 0; k < 4 && q.size() != 0; k++) begin
      #1;
      total++;
      if (out_data_o !== q[0]) $display("FAIL rand_drain k=%0d act=%h exp=%h", k, out_data_o, q[0]); else passed++;
      void'(q.pop_front());
      cyc();
    end
    #1;
    total++; if (occupancy_o !== 2'd0 || q.size() != 0) $display("FAIL rand_final occ=%0d left=%0d exp=0", occupancy_o, q.size()); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1; idle();
    test_reset();
    test_stream();
    test_stall_fill();
    test_flush_full();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
